// File: rtl/dispense_controller.sv
// Dispense controller: opens the valve on OK and counts flow-meter pulses (1 pulse = 1 mL) up to the latched target.
// Optional flow watchdog with a sticky fault state is enabled by defining DISPENSER_TIMEOUT_EN.
module dispense_controller #(
  parameter int AMOUNT_WIDTH   = 14,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [AMOUNT_WIDTH-1:0] requested_amount,
  input  logic                    ok_pressed,
  input  logic                    cancel_pressed,
  input  logic                    flow_pulse,
  output logic                    valve_open,
  output logic                    busy,
  output logic [AMOUNT_WIDTH-1:0] dispensed_amount,
  output logic                    done,
  output logic                    aborted,
  output logic                    fault
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] DISPENSING = 2'd1;
`ifdef DISPENSER_TIMEOUT_EN
  localparam logic [1:0] FAULT      = 2'd2;
  localparam int         WDOG_W     = $clog2(TIMEOUT_CYCLES + 1);
`endif

  logic [1:0]              state_q, state_d;
  logic [AMOUNT_WIDTH-1:0] target_q, target_d;
  logic [AMOUNT_WIDTH-1:0] count_q, count_d;
  logic                    valve_q, valve_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    fault_q, fault_d;
  logic                    flowS0_q, flowS1_q, flowPrev_q;
  logic                    flowEdge;
  logic [AMOUNT_WIDTH-1:0] countInc;

  // Flow meter is asynchronous: two-flop synchronizer, then rising-edge detect.
  assign flowEdge = flowS1_q & ~flowPrev_q;
  assign countInc = count_q + AMOUNT_WIDTH'(1);

`ifdef DISPENSER_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeoutHit;
  assign timeoutHit = (wdog_q + WDOG_W'(1)) == WDOG_W'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    count_d   = count_q;
    valve_d   = valve_q;
    busy_d    = busy_q;
    fault_d   = fault_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
`ifdef DISPENSER_TIMEOUT_EN
    wdog_d    = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (ok_pressed && (requested_amount != '0)) begin
          state_d  = DISPENSING;
          target_d = requested_amount;
          count_d  = '0;
          valve_d  = 1'b1;
          busy_d   = 1'b1;
`ifdef DISPENSER_TIMEOUT_EN
          wdog_d   = '0;
`endif
        end
      end
      DISPENSING: begin
`ifdef DISPENSER_TIMEOUT_EN
        wdog_d = flowEdge ? '0 : wdog_q + WDOG_W'(1);
`endif
        if (flowEdge) begin
          count_d = countInc;
        end
        // Cancel has priority over reaching the target in the same cycle.
        if (cancel_pressed) begin
          state_d   = IDLE;
          valve_d   = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (flowEdge && (countInc == target_q)) begin
          state_d = IDLE;
          valve_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
`ifdef DISPENSER_TIMEOUT_EN
        else if (!flowEdge && timeoutHit) begin
          state_d = FAULT;
          valve_d = 1'b0;
          busy_d  = 1'b0;
          fault_d = 1'b1;
        end
`endif
      end
`ifdef DISPENSER_TIMEOUT_EN
      FAULT: begin
        if (cancel_pressed) begin
          state_d   = IDLE;
          fault_d   = 1'b0;
          aborted_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        valve_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      target_q   <= '0;
      count_q    <= '0;
      valve_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      fault_q    <= 1'b0;
      flowS0_q   <= 1'b0;
      flowS1_q   <= 1'b0;
      flowPrev_q <= 1'b0;
`ifdef DISPENSER_TIMEOUT_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      count_q    <= count_d;
      valve_q    <= valve_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      fault_q    <= fault_d;
      flowS0_q   <= flow_pulse;
      flowS1_q   <= flowS0_q;
      flowPrev_q <= flowS1_q;
`ifdef DISPENSER_TIMEOUT_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign valve_open       = valve_q;
  assign busy             = busy_q;
  assign dispensed_amount = count_q;
  assign done             = done_q;
  assign aborted          = aborted_q;
`ifdef DISPENSER_TIMEOUT_EN
  assign fault            = fault_q;
`else
  assign fault            = 1'b0;
`endif

endmodule

// File: tb/tb_dispense_controller.sv
// Directed bench for dispense_controller; inputs change and outputs are checked on the falling clock edge.
// The DISPENSER_TIMEOUT_EN section runs only when the design is built with that macro.
module tb_dispense_controller;

  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] requested_amount;
  logic          ok_pressed;
  logic          cancel_pressed;
  logic          flow_pulse;
  logic          valve_open;
  logic          busy;
  logic [AW-1:0] dispensed_amount;
  logic          done;
  logic          aborted;
  logic          fault;

  int testCount = 0;
  int failCount = 0;

  dispense_controller #(
    .AMOUNT_WIDTH   (AW),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .requested_amount (requested_amount),
    .ok_pressed       (ok_pressed),
    .cancel_pressed   (cancel_pressed),
    .flow_pulse       (flow_pulse),
    .valve_open       (valve_open),
    .busy             (busy),
    .dispensed_amount (dispensed_amount),
    .done             (done),
    .aborted          (aborted),
    .fault            (fault)
  );

  always #5 clock = ~clock;

  // Advance one full cycle, ending on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Drive single-cycle pulses on the control inputs, then release them.
  task automatic applyStimulus(input logic okIn, input logic cancelIn, input logic flowIn);
    ok_pressed     = okIn;
    cancel_pressed = cancelIn;
    flow_pulse     = flowIn;
    tick();
    ok_pressed     = 1'b0;
    cancel_pressed = 1'b0;
    flow_pulse     = 1'b0;
  endtask

  // One flow-meter pulse; returns after the count has had time to update.
  task automatic flowPulse();
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic b, input int cnt,
                          input logic d, input logic a, input logic f);
    checkOutput({tag, ".valve"}, {31'd0, valve_open}, {31'd0, v});
    checkOutput({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    checkOutput({tag, ".count"}, {18'd0, dispensed_amount}, cnt);
    checkOutput({tag, ".done"}, {31'd0, done}, {31'd0, d});
    checkOutput({tag, ".aborted"}, {31'd0, aborted}, {31'd0, a});
    checkOutput({tag, ".fault"}, {31'd0, fault}, {31'd0, f});
  endtask

  initial begin
    reset            = 1'b1;
    requested_amount = '0;
    ok_pressed       = 1'b0;
    cancel_pressed   = 1'b0;
    flow_pulse       = 1'b0;
    @(negedge clock);
    tick();
    tick();
    checkAll("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // Normal run of 3 mL; entry changes mid-run must not affect the latched target.
    requested_amount = 14'd3;
    applyStimulus(1'b1, 1'b0, 1'b0);
    requested_amount = 14'd1;
    checkAll("start3", 1, 1, 0, 0, 0, 0);
    flowPulse();
    checkAll("run3.p1", 1, 1, 1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkAll("run3.okIgnored", 1, 1, 1, 0, 0, 0);
    flowPulse();
    checkAll("run3.p2", 1, 1, 2, 0, 0, 0);
    flowPulse();
    checkAll("run3.p3", 0, 0, 3, 1, 0, 0);
    tick();
    checkAll("run3.after", 0, 0, 3, 0, 0, 0);

    // Zero entry is ignored; cancel while idle gives no abort.
    requested_amount = 14'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkAll("zero", 0, 0, 3, 0, 0, 0);
    tick();
    checkAll("zero.later", 0, 0, 3, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkAll("idleCancel", 0, 0, 3, 0, 0, 0);

    // Cancel after 4 of 10 mL.
    requested_amount = 14'd10;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkAll("start10", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) flowPulse();
    checkAll("run10.p4", 1, 1, 4, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkAll("cancel10", 0, 0, 4, 0, 1, 0);
    tick();
    checkAll("cancel10.hold", 0, 0, 4, 0, 0, 0);

    // Cancel in the same cycle as the final flow edge of a 2 mL run.
    requested_amount = 14'd2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    flowPulse();
    checkAll("run2.p1", 1, 1, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkAll("simul", 0, 0, 2, 0, 1, 0);
    tick();
    checkAll("simul.after", 0, 0, 2, 0, 0, 0);

    // Reset mid-run, then residual flow must not be counted.
    requested_amount = 14'd5;
    applyStimulus(1'b1, 1'b0, 1'b0);
    flowPulse();
    flowPulse();
    checkAll("run5.p2", 1, 1, 2, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkAll("midReset", 0, 0, 0, 0, 0, 0);
    flowPulse();
    checkAll("idleFlow", 0, 0, 0, 0, 0, 0);

`ifdef DISPENSER_TIMEOUT_EN
    // Watchdog of 100 cycles with no flow.
    requested_amount = 14'd5;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 99; i++) tick();
    checkAll("wdog.99", 1, 1, 0, 0, 0, 0);
    tick();
    checkAll("wdog.fault", 0, 0, 0, 0, 0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkAll("fault.okIgnored", 0, 0, 0, 0, 0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkAll("fault.cancel", 0, 0, 0, 0, 1, 0);
    tick();
    checkAll("fault.idle", 0, 0, 0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
